// File: rtl/i2c_byte_master_if.sv
// Host-side command/response handshake of the I2C byte engine.
interface i2c_byte_master_if;
    logic [3:0] cmd;
    logic       cmd_en;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_valid;
    logic       ready;
    logic       nack_o;

    modport master (output cmd, cmd_en, data_i, input data_o, data_valid, ready, nack_o);
    modport slave  (input cmd, cmd_en, data_i, output data_o, data_valid, ready, nack_o);
endinterface

// File: rtl/i2c_byte_master.sv
// Single-master I2C byte engine: START/STOP/WRITE/READ commands, each split into
// 4-phase bit slots of DIV clocks; SCL push-pull, SDA open-drain.
module i2c_byte_master #(
    parameter int unsigned DIV = 8
) (
    input  logic            clk_i,
    input  logic            reset_n,
    i2c_byte_master_if.slave host,
    inout  wire             sda_io,
    output logic            scl_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] OP_START   = 3'd1;
    localparam logic [2:0] OP_STOP    = 3'd2;
    localparam logic [2:0] OP_WRITE   = 3'd3;
    localparam logic [2:0] OP_RD_NACK = 3'd4;
    localparam logic [2:0] OP_RD_ACK  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [3:0]    last_bit;
    logic [2:0]    op_q, op_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          ready_d, valid_d, nack_d;
    logic [7:0]    data_o_d;
    logic          sda_in;
    logic          cmd_ok;

    assign sda_io   = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in   = sda_io;
    assign cmd_ok   = host.cmd_en && (host.cmd >= 4'd1) && (host.cmd <= 4'd5);
    assign last_bit = (op_q == OP_START || op_q == OP_STOP) ? 4'd0 : 4'd8;

    // Bus levels {scl, sda_oe} for a given op/bit/phase position
    function automatic logic [1:0] bus_level(input logic [2:0] op, input logic [1:0] ph,
                                             input logic [3:0] bn, input logic [7:0] tx,
                                             input logic scl_now);
        logic scl_b;
        logic oe_b;
        scl_b = (ph == 2'd1) || (ph == 2'd2);
        oe_b  = 1'b0;
        case (op)
            OP_START: begin
                scl_b = (ph == 2'd0) ? scl_now : (ph != 2'd3);
                oe_b  = ph[1];
            end
            OP_STOP: begin
                scl_b = (ph != 2'd0);
                oe_b  = (ph < 2'd2);
            end
            OP_WRITE:  oe_b = (bn < 4'd8) ? ~tx[~bn[2:0]] : 1'b0;
            OP_RD_ACK: oe_b = (bn == 4'd8);
            default:   oe_b = 1'b0;
        endcase
        return {scl_b, oe_b};
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        op_d     = op_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        scl_d    = scl_o;
        sda_oe_d = sda_oe_q;
        ready_d  = 1'b0;
        valid_d  = 1'b0;
        nack_d   = host.nack_o;
        data_o_d = host.data_o;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (cmd_ok) begin
                    op_d    = host.cmd[2:0];
                    tx_d    = host.data_i;
                    cnt_d   = '0;
                    phase_d = 2'd0;
                    bit_d   = 4'd0;
                    state_d = S_RUN;
                    ready_d = 1'b0;
                    {scl_d, sda_oe_d} = bus_level(host.cmd[2:0], 2'd0, 4'd0, host.data_i, scl_o);
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    // End of the first SCL-high phase: sample data / ACK slot
                    if (phase_q == 2'd1 && (bit_q < 4'd8 || op_q == OP_WRITE))
                        rx_d = {rx_q[6:0], sda_in};
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        if (bit_q == last_bit) state_d = S_DONE;
                        else                   bit_d   = bit_q + 4'd1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (state_d == S_RUN)
                    {scl_d, sda_oe_d} = bus_level(op_q, phase_d, bit_d, tx_q, scl_o);
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                if (op_q == OP_WRITE) nack_d = rx_q[0];
                if (op_q == OP_RD_NACK || op_q == OP_RD_ACK) begin
                    data_o_d = rx_q;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            phase_q         <= 2'd0;
            bit_q           <= 4'd0;
            op_q            <= 3'd0;
            tx_q            <= 8'h00;
            rx_q            <= 8'h00;
            scl_o           <= 1'b1;
            sda_oe_q        <= 1'b0;
            host.ready      <= 1'b1;
            host.data_valid <= 1'b0;
            host.data_o     <= 8'h00;
            host.nack_o     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            phase_q         <= phase_d;
            bit_q           <= bit_d;
            op_q            <= op_d;
            tx_q            <= tx_d;
            rx_q            <= rx_d;
            scl_o           <= scl_d;
            sda_oe_q        <= sda_oe_d;
            host.ready      <= ready_d;
            host.data_valid <= valid_d;
            host.data_o     <= data_o_d;
            host.nack_o     <= nack_d;
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Scoreboard bench for i2c_byte_master: stimulus pushes expectations, monitors
// on the host handshake and on the I2C bus (slave model) pop and compare.
module tb_i2c_byte_master;
    localparam int unsigned DIV       = 8;
    localparam int unsigned BYTE_BUSY = 36 * DIV + 1;
    localparam int unsigned COND_BUSY = 4 * DIV + 1;

    typedef struct {
        int         busy;
        logic       scl_end;
        logic       chk_sda;
        logic       sda_end;
        logic       nack;
        logic [7:0] data;
        logic       dv;
    } host_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       ack;
    } byte_exp_t;

    logic clk_i = 1'b0;
    logic reset_n;
    logic scl;
    wire  sda;
    logic slave_oe;

    i2c_byte_master_if bus();

    pullup (sda);
    assign sda = slave_oe ? 1'b0 : 1'bz;

    i2c_byte_master #(.DIV(DIV)) dut (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .host    (bus.slave),
        .sda_io  (sda),
        .scl_o   (scl)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    host_exp_t  host_q[$];
    byte_exp_t  byte_q[$];
    logic [7:0] cond_q[$];

    logic       model_nack = 1'b0;
    logic [7:0] model_rd   = 8'h00;

    // Slave model controls: 0 = passive, 1 = write target, 2 = read source
    int         slave_mode = 0;
    logic       slave_ack  = 1'b0;
    logic [7:0] slave_rd   = 8'h00;
    int         drv_idx    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always_comb begin
        slave_oe = 1'b0;
        if (slave_mode == 1)
            slave_oe = slave_ack && (drv_idx == 8);
        else if (slave_mode == 2 && drv_idx < 8)
            slave_oe = ~slave_rd[7 - drv_idx];
    end

    // Bus monitor + slave receiver: START/STOP conditions and 9-bit byte slots
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitcnt   = 0;
    logic [8:0] shreg    = 9'h000;

    task automatic cond_seen(input logic [7:0] c);
        logic [7:0] e;
        if (cond_q.size() == 0) begin
            check("unexpected_condition", 32'(c), 32'h0);
        end else begin
            e = cond_q.pop_front();
            check("bus_condition", 32'(c), 32'(e));
        end
    endtask

    task automatic byte_seen(input logic [8:0] s);
        byte_exp_t e;
        if (byte_q.size() == 0) begin
            check("unexpected_byte", 32'(s), 32'h0);
        end else begin
            e = byte_q.pop_front();
            check("slave_byte", 32'(s[8:1]), 32'(e.data));
            check("slave_ack_bit", 32'(s[0]), 32'(e.ack));
        end
    endtask

    always @(negedge clk_i) begin
        if (!reset_n) begin
            bitcnt  = 0;
            drv_idx = 0;
        end else begin
            if (prev_scl && scl && prev_sda && !sda) begin
                cond_seen("S");
                bitcnt = 0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                cond_seen("P");
                bitcnt = 0;
            end
            if (!prev_scl && scl) begin
                shreg = {shreg[7:0], sda};
                bitcnt++;
                if (bitcnt == 9) begin
                    byte_seen(shreg);
                    bitcnt = 0;
                end
            end
            if (prev_scl && !scl) drv_idx = bitcnt;
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // Host monitor: one expectation per command, popped when ready returns
    int   busy     = 0;
    logic prev_rdy = 1'b1;
    logic dv_next  = 1'b0;

    always @(negedge clk_i) begin
        host_exp_t e;
        if (!reset_n) begin
            busy     = 0;
            prev_rdy = 1'b1;
            dv_next  = 1'b0;
        end else begin
            if (dv_next) begin
                check("data_valid_width", 32'(bus.data_valid), 32'h0);
                dv_next = 1'b0;
            end
            if (!bus.ready) begin
                busy++;
            end else if (!prev_rdy) begin
                if (host_q.size() == 0) begin
                    check("unexpected_completion", 32'(busy), 32'h0);
                end else begin
                    e = host_q.pop_front();
                    check("busy_cycles", 32'(busy), 32'(e.busy));
                    check("scl_at_end", 32'(scl), 32'(e.scl_end));
                    if (e.chk_sda) check("sda_at_end", 32'(sda), 32'(e.sda_end));
                    check("nack_o", 32'(bus.nack_o), 32'(e.nack));
                    check("data_o", 32'(bus.data_o), 32'(e.data));
                    check("data_valid", 32'(bus.data_valid), 32'(e.dv));
                    dv_next = e.dv;
                end
                busy = 0;
            end
            prev_rdy = bus.ready;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'h1);
    endtask

    task automatic handshake(input logic [3:0] c, input logic [7:0] d);
        @(negedge clk_i);
        bus.cmd    = c;
        bus.data_i = d;
        bus.cmd_en = 1'b1;
        @(negedge clk_i);
        bus.cmd_en = 1'b0;
        bus.cmd    = 4'd0;
    endtask

    task automatic push_host(input int b, input logic s_end, input logic chk, input logic d_end,
                             input logic dv);
        host_exp_t e;
        e.busy = b; e.scl_end = s_end; e.chk_sda = chk; e.sda_end = d_end;
        e.nack = model_nack; e.data = model_rd; e.dv = dv;
        host_q.push_back(e);
    endtask

    task automatic do_start();
        wait_ready();
        slave_mode = 0;
        cond_q.push_back("S");
        push_host(COND_BUSY, 1'b0, 1'b1, 1'b0, 1'b0);
        handshake(4'd1, 8'h00);
    endtask

    task automatic do_stop();
        wait_ready();
        slave_mode = 0;
        cond_q.push_back("P");
        push_host(COND_BUSY, 1'b1, 1'b1, 1'b1, 1'b0);
        handshake(4'd2, 8'h00);
    endtask

    task automatic do_write(input logic [7:0] b, input logic ack);
        wait_ready();
        slave_mode = 1;
        slave_ack  = ack;
        byte_q.push_back('{data: b, ack: !ack});
        model_nack = !ack;
        push_host(BYTE_BUSY, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake(4'd3, b);
    endtask

    task automatic do_read(input logic [7:0] b, input logic ack);
        wait_ready();
        slave_mode = 2;
        slave_rd   = b;
        byte_q.push_back('{data: b, ack: !ack});
        model_rd = b;
        push_host(BYTE_BUSY, 1'b0, 1'b0, 1'b0, 1'b1);
        handshake(ack ? 4'd5 : 4'd4, 8'h00);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(bus.ready), 32'h1);
        check({tag, "_scl"}, 32'(scl), 32'h1);
        check({tag, "_sda"}, 32'(sda), 32'h1);
    endtask

    initial begin
        bus.cmd    = 4'd0;
        bus.cmd_en = 1'b0;
        bus.data_i = 8'h00;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk_i);
        check_idle("reset");
        check("reset_data_valid", 32'(bus.data_valid), 32'h0);
        check("reset_data_o", 32'(bus.data_o), 32'h0);
        check("reset_nack", 32'(bus.nack_o), 32'h0);
        reset_n = 1'b1;

        // NOP and out-of-range codes are ignored
        bus.cmd    = 4'd0;
        bus.cmd_en = 1'b1;
        repeat (10) @(negedge clk_i);
        check_idle("nop");
        bus.cmd = 4'd7;
        repeat (10) @(negedge clk_i);
        check_idle("invalid_cmd");
        bus.cmd_en = 1'b0;
        bus.cmd    = 4'd0;

        do_start();
        do_write(8'hD0, 1'b1);
        // A command strobe while busy must be ignored
        repeat (40) @(negedge clk_i);
        bus.cmd    = 4'd2;
        bus.cmd_en = 1'b1;
        repeat (4) @(negedge clk_i);
        bus.cmd_en = 1'b0;
        bus.cmd    = 4'd0;
        do_write(8'h6B, 1'b0);
        do_start();
        do_write(8'h3B, 1'b1);
        do_start();
        do_write(8'hD1, 1'b1);
        do_read(8'hA5, 1'b0);
        do_read(8'h3C, 1'b1);
        do_stop();

        // Reset mid-WRITE while SDA is driven low
        do_start();
        wait_ready();
        slave_mode = 1;
        slave_ack  = 1'b1;
        handshake(4'd3, 8'hA5);
        repeat (100) @(negedge clk_i);
        #2 reset_n = 1'b0;
        #1;
        check_idle("abort");
        check("abort_data_valid", 32'(bus.data_valid), 32'h0);
        check("abort_data_o", 32'(bus.data_o), 32'h0);
        model_nack = 1'b0;
        model_rd   = 8'h00;
        slave_mode = 0;
        repeat (3) @(negedge clk_i);
        reset_n = 1'b1;

        do_start();
        do_stop();
        wait_ready();
        repeat (5) @(negedge clk_i);

        check("host_queue_drained", 32'(host_q.size()), 32'h0);
        check("byte_queue_drained", 32'(byte_q.size()), 32'h0);
        check("cond_queue_drained", 32'(cond_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
